microcode_sequencer: RTL
========================

// Module: microcode_sequencer
// PURPOSE
//  Drives the 10-bit microcode address into the microcode ROM and walks each instruction's micro-op chain.
//  It accepts fetched opcode bytes, handles the 0xCB prefix, stalls on memory, exits conditional ops early,
//  and handles interrupt dispatch and HALT. It sits between the fetch unit and the microcode ROM.
//  The 76-bit control word comes back from the ROM in the same cycle and is decoded only for sequencing fields.
// PARAMETERS
//  IDLE_ADDR    10'h22E  ROM entry with an all-zero (no-op) control word; driven whenever not executing
//  INT_ADDR     10'h200  first micro-op of the interrupt-dispatch chain
//  CB_BASE      10'h100  dispatch base for CB-prefixed opcodes (non-CB base is 10'h000)
//  LAST_BIT     75       control-word bit: this micro-op ends the instruction
//  WAIT_BIT     74       control-word bit: hold this micro-op until mem_ready
//  COND_BIT     73       control-word bit: conditional checkpoint
//  HALT_BIT     72       control-word bit: enter HALT after this (last) micro-op
//  CSEL_LSB     70       2-bit condition select: 00 NZ, 01 Z, 10 NC, 11 C
//  NEXT_LSB     60       10-bit next-micro-address field
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  instr_byte     in   8   fetched opcode byte
//  instr_valid    in   1   instr_byte valid
//  instr_ready    out  1   sequencer accepts instr_byte this cycle
//  control_signals in  76  ROM output for ucode_addr (combinational, same cycle)
//  ucode_addr     out  10  registered microcode ROM address
//  uop_valid      out  1   control_signals are an active micro-op this cycle
//  uop_advance    out  1   micro-op completes this cycle (datapath commits)
//  mem_ready      in   1   memory access of the current micro-op finishes this cycle
//  flag_z, flag_c in   1   ALU flags for conditional checkpoints
//  int_req        in   1   interrupt pending and enabled
//  int_ack        out  1   one-cycle pulse: interrupt dispatch taken
//  instr_done     out  1   one-cycle pulse: instruction retired
//  cb_mode        out  1   current/pending instruction is CB-prefixed
//  halted         out  1   sequencer is in HALT
// BEHAVIOUR
//  Reset (async): state=IDLE, ucode_addr=IDLE_ADDR, cb_mode=0. All pulse outputs read 0.
//  States: IDLE, EXEC, HALT. Decoded terms: last=cw[LAST_BIT], wt=cw[WAIT_BIT], cnd=cw[COND_BIT],
//   cfail = cnd & condition(CSEL) false, stall = wt & !mem_ready.
//  IDLE:
//   - instr_ready=1 unless int_req. uop_valid=0. ucode_addr=IDLE_ADDR.
//   - int_req has priority: int_ack=1, ucode_addr<=INT_ADDR, go to EXEC.
//     A simultaneous instr_valid byte is NOT accepted.
//   - Else instr_valid and byte==8'hCB and !cb_mode: cb_mode<=1, stay IDLE (prefix consumes 1 cycle).
//   - Else instr_valid: ucode_addr <= (cb_mode ? CB_BASE : 0) + byte, go to EXEC.
//  EXEC:
//   - uop_valid=1, instr_ready=0. uop_advance = !stall.
//   - stall: hold ucode_addr and state. A hold of any length is legal.
//   - !stall & (last | cfail): instr_done=1, cb_mode<=0, ucode_addr<=IDLE_ADDR.
//     Go to HALT if cw[HALT_BIT] & !cfail, else go to IDLE.
//   - !stall otherwise: ucode_addr <= cw[NEXT_LSB+:10], stay EXEC.
//   - A CB flag ending an instruction can never be seen; cb_mode clears only on instr_done.
//  HALT:
//   - halted=1, uop_valid=0, instr_ready=0, ucode_addr=IDLE_ADDR.
//   - int_req: go to IDLE next cycle (no ack here; dispatch occurs from IDLE).
//  Latency:
//   - Byte accepted at edge N -> first micro-op is valid in cycle N+1.
//   - Single-uop instruction: instr_done in cycle N+1, next byte accepted in cycle N+2.
//  Flags are sampled in the checkpoint cycle only. NEXT field is ignored when last|cfail.
//  Reset mid-instruction abandons the chain immediately. No partial state survives.
// TESTING
//  1. 0x00 (single-uop, LAST) -> ucode_addr=0x000 one cycle, instr_done pulse, back to IDLE_ADDR.
//  2. 0xCB then 0x37 -> cb_mode=1 after first byte, ucode_addr=0x137, cb_mode=0 after done.
//  3. WAIT uop with mem_ready low 3 cycles -> ucode_addr held 4 cycles, uop_advance=1 only on 4th.
//  4. COND NZ checkpoint: flag_z=1 -> instr_done at checkpoint; flag_z=0 -> continues to NEXT addr.
//  5. int_req & instr_valid same IDLE cycle -> int_ack, ucode_addr=INT_ADDR, byte not consumed.
//  6. HALT uop retires -> halted=1. int_req -> IDLE, then int_ack. Async rst mid-EXEC -> IDLE_ADDR at once.

Source files
------------

// File: rtl/microcode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_sequencer
//  Description : Microcode ROM address sequencer. Accepts opcode bytes from
//                fetch (with 0xCB prefix handling), walks each instruction's
//                micro-op chain, stalls on memory, exits early on failed
//                conditional checkpoints, dispatches interrupts and handles
//                HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_sequencer #(
    parameter logic [9:0] IDLE_ADDR = 10'h22E,
    parameter logic [9:0] INT_ADDR  = 10'h200,
    parameter logic [9:0] CB_BASE   = 10'h100,
    parameter int         LAST_BIT  = 75,
    parameter int         WAIT_BIT  = 74,
    parameter int         COND_BIT  = 73,
    parameter int         HALT_BIT  = 72,
    parameter int         CSEL_LSB  = 70,
    parameter int         NEXT_LSB  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  instr_byte,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [75:0] control_signals,
    output logic [9:0]  ucode_addr,
    output logic        uop_valid,
    output logic        uop_advance,
    input  logic        mem_ready,
    input  logic        flag_z,
    input  logic        flag_c,
    input  logic        int_req,
    output logic        int_ack,
    output logic        instr_done,
    output logic        cb_mode,
    output logic        halted
);

    localparam logic [9:0] c_BASE_PLAIN = 10'h000;
    localparam logic [7:0] c_CB_PREFIX  = 8'hCB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     r_state, w_next_state;
    logic [9:0] r_ucode_addr, w_next_addr;
    logic       r_cb_mode, w_next_cb;

    logic       w_last, w_wait, w_cond, w_halt_op;
    logic [1:0] w_csel;
    logic [9:0] w_next_field;
    logic       w_cond_true, w_cfail, w_stall;
    logic       w_unused_cw;

    // Only the sequencing fields are decoded; the rest belongs to the datapath.
    assign w_last       = control_signals[LAST_BIT];
    assign w_wait       = control_signals[WAIT_BIT];
    assign w_cond       = control_signals[COND_BIT];
    assign w_halt_op    = control_signals[HALT_BIT];
    assign w_csel       = control_signals[CSEL_LSB +: 2];
    assign w_next_field = control_signals[NEXT_LSB +: 10];
    assign w_unused_cw  = ^control_signals[NEXT_LSB-1:0];

    // Evaluate the selected flag condition for a checkpoint micro-op.
    always_comb begin
        w_cond_true = 1'b0;
        case (w_csel)
            2'b00:   w_cond_true = !flag_z;
            2'b01:   w_cond_true = flag_z;
            2'b10:   w_cond_true = !flag_c;
            default: w_cond_true = flag_c;
        endcase
    end

    assign w_cfail = w_cond & !w_cond_true;
    assign w_stall = w_wait & !mem_ready;

    // Next-state, next-address and handshake/pulse outputs.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_ucode_addr;
        w_next_cb    = r_cb_mode;
        instr_ready  = 1'b0;
        uop_valid    = 1'b0;
        uop_advance  = 1'b0;
        int_ack      = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = !int_req;
                w_next_addr = IDLE_ADDR;
                if (int_req) begin
                    // Interrupt wins; any byte offered this cycle stays in fetch.
                    int_ack      = 1'b1;
                    w_next_addr  = INT_ADDR;
                    w_next_state = S_EXEC;
                end else if (instr_valid) begin
                    if (instr_byte == c_CB_PREFIX && !r_cb_mode) begin
                        w_next_cb = 1'b1;
                    end else begin
                        w_next_addr  = (r_cb_mode ? CB_BASE : c_BASE_PLAIN)
                                     + {2'b00, instr_byte};
                        w_next_state = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                uop_valid   = 1'b1;
                uop_advance = !w_stall;
                if (!w_stall) begin
                    if (w_last || w_cfail) begin
                        instr_done   = 1'b1;
                        w_next_cb    = 1'b0;
                        w_next_addr  = IDLE_ADDR;
                        w_next_state = (w_halt_op && !w_cfail) ? S_HALT : S_IDLE;
                    end else begin
                        w_next_addr = w_next_field;
                    end
                end
            end
            S_HALT: begin
                halted      = 1'b1;
                w_next_addr = IDLE_ADDR;
                if (int_req) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_addr  = IDLE_ADDR;
                w_next_cb    = 1'b0;
            end
        endcase
    end

    // State, ROM address and prefix flag registers; reset abandons any chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ucode_addr <= IDLE_ADDR;
            r_cb_mode    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ucode_addr <= w_next_addr;
            r_cb_mode    <= w_next_cb;
        end
    end

    assign ucode_addr = r_ucode_addr;
    assign cb_mode    = r_cb_mode;

endmodule
`default_nettype wire
